// File: rtl/wb_gpio_ex.sv
// Wishbone GPIO block: output latch, per-bit output enable, edge interrupts with W1C pending bits.
// Optional input debounce filter is enabled by defining GPIO_DEBOUNCE_EN.
module wb_gpio_ex #(
    parameter int          GPIO_WIDTH             = 32,
    parameter logic [31:0] DEFAULT_INTERRUPT_MASK = 32'h0,
    parameter logic [31:0] DEFAULT_INTERRUPT_EDGE = 32'h0,
    parameter logic [31:0] DEFAULT_INTERRUPT_BOTH = 32'h0,
    parameter int          DEBOUNCE_DIV           = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wbs_we,
    input  logic                  i_wbs_cyc,
    input  logic [3:0]            i_wbs_sel,
    input  logic [31:0]           i_wbs_dat,
    input  logic                  i_wbs_stb,
    output logic                  o_wbs_ack,
    output logic [31:0]           o_wbs_dat,
    input  logic [31:0]           i_wbs_adr,
    output logic                  o_wbs_int,
    output logic [GPIO_WIDTH-1:0] o_gpio_out,
    output logic [GPIO_WIDTH-1:0] o_gpio_oe,
    input  logic [GPIO_WIDTH-1:0] i_gpio_in
);
    localparam int W = GPIO_WIDTH;

    logic         ack_q, ack_d, irq_q, irq_d;
    logic [31:0]  dat_q, dat_d, rdata, bm32;
    logic [W-1:0] out_q, out_d, oe_q, oe_d, pend_q, pend_d;
    logic [W-1:0] ien_q, ien_d, edge_q, edge_d, both_q, both_d;
    logic [W-1:0] sync1_q, sync2_q, prev_q, filt;
    logic [W-1:0] wd, wm, clr, rise, fall, ev;
    logic [1:0]   guard_q, guard_d;
    logic         req;

`ifdef GPIO_DEBOUNCE_EN
    localparam int DW = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;
    logic [DW-1:0] div_q, div_d;
    logic [W-1:0]  smp1_q, smp1_d, smp2_q, smp2_d, filt_q, filt_d, stable;
    logic          tick;

    // A bit's filtered value moves only when three consecutive tick samples agree.
    always_comb begin
        tick   = (div_q == DW'(DEBOUNCE_DIV - 1));
        div_d  = tick ? '0 : div_q + DW'(1);
        smp1_d = smp1_q;
        smp2_d = smp2_q;
        filt_d = filt_q;
        stable = ~(sync2_q ^ smp1_q) & ~(smp1_q ^ smp2_q);
        if (tick) begin
            smp1_d = sync2_q;
            smp2_d = smp1_q;
            filt_d = (filt_q & ~stable) | (sync2_q & stable);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q  <= '0;
            smp1_q <= '0;
            smp2_q <= '0;
            filt_q <= '0;
        end else begin
            div_q  <= div_d;
            smp1_q <= smp1_d;
            smp2_q <= smp2_d;
            filt_q <= filt_d;
        end
    end

    assign filt = filt_q;
`else
    assign filt = sync2_q;
`endif

    assign req = i_wbs_cyc & i_wbs_stb & ~ack_q;
    assign wd  = i_wbs_dat[W-1:0];
    assign wm  = bm32[W-1:0];

    always_comb begin
        for (int i = 0; i < 4; i++) bm32[8*i +: 8] = {8{i_wbs_sel[i]}};
    end

    // History follows the filtered value every cycle, whatever oe is, so an
    // oe 1->0 transition never sees a stale previous value.
    always_comb begin
        rise = filt & ~prev_q;
        fall = ~filt & prev_q;
        ev   = ~oe_q & ((both_q & (rise | fall)) |
                        (~both_q & edge_q & rise) |
                        (~both_q & ~edge_q & fall));
        if (guard_q != 2'd3) ev = '0;
        guard_d = (guard_q == 2'd3) ? guard_q : guard_q + 2'd1;
    end

    always_comb begin
        rdata = '0;
        case (i_wbs_adr)
            32'd0:   rdata = 32'((sync2_q & ~oe_q) | (out_q & oe_q));
            32'd1:   rdata = 32'(oe_q);
            32'd2:   rdata = 32'(pend_q);
            32'd3:   rdata = 32'(ien_q);
            32'd4:   rdata = 32'(edge_q);
            32'd5:   rdata = 32'(both_q);
            default: rdata = '0;
        endcase
    end

    always_comb begin
        out_d  = out_q;
        oe_d   = oe_q;
        ien_d  = ien_q;
        edge_d = edge_q;
        both_d = both_q;
        clr    = '0;
        if (req && i_wbs_we) begin
            case (i_wbs_adr)
                32'd0:   out_d  = (out_q  & ~wm) | (wd & wm);
                32'd1:   oe_d   = (oe_q   & ~wm) | (wd & wm);
                32'd2:   clr    = wd & wm;
                32'd3:   ien_d  = (ien_q  & ~wm) | (wd & wm);
                32'd4:   edge_d = (edge_q & ~wm) | (wd & wm);
                32'd5:   both_d = (both_q & ~wm) | (wd & wm);
                32'd6:   out_d  = out_q | (wd & wm);
                32'd7:   out_d  = out_q & ~(wd & wm);
                default: ;
            endcase
        end
        // A new event on the same cycle as its clear keeps the bit pending.
        pend_d = (pend_q & ~clr) | ev;
        ack_d  = req;
        dat_d  = req ? rdata : dat_q;
        irq_d  = |(pend_q & ien_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ack_q   <= 1'b0;
            dat_q   <= '0;
            irq_q   <= 1'b0;
            out_q   <= '0;
            oe_q    <= '0;
            pend_q  <= '0;
            ien_q   <= DEFAULT_INTERRUPT_MASK[W-1:0];
            edge_q  <= DEFAULT_INTERRUPT_EDGE[W-1:0];
            both_q  <= DEFAULT_INTERRUPT_BOTH[W-1:0];
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            guard_q <= '0;
        end else begin
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            irq_q   <= irq_d;
            out_q   <= out_d;
            oe_q    <= oe_d;
            pend_q  <= pend_d;
            ien_q   <= ien_d;
            edge_q  <= edge_d;
            both_q  <= both_d;
            sync1_q <= i_gpio_in;
            sync2_q <= sync1_q;
            prev_q  <= filt;
            guard_q <= guard_d;
        end
    end

    assign o_wbs_ack  = ack_q;
    assign o_wbs_dat  = dat_q;
    assign o_wbs_int  = irq_q;
    assign o_gpio_out = out_q;
    assign o_gpio_oe  = oe_q;
endmodule

// File: tb/tb_wb_gpio_ex.sv
// Randomized bench: a 32-bit and an 8-bit instance share one bus and pads; both follow one bitwise model.
module tb_wb_gpio_ex;
`ifdef GPIO_DEBOUNCE_EN
    localparam int HOLD = 40;
    localparam int LAT  = 30;
`else
    localparam int HOLD = 8;
    localparam int LAT  = 4;
`endif

    logic        clk, rst, we, cyc, stb;
    logic [3:0]  sel;
    logic [31:0] dat, adr, gpio_in;
    logic        ack32, ack8, irq32, irq8;
    logic [31:0] rd32_o, out32, oe32;
    logic [31:0] rd8_o;
    logic [7:0]  out8, oe8;

    wb_gpio_ex #(.GPIO_WIDTH(32), .DEBOUNCE_DIV(4)) dut32 (
        .clk(clk), .rst(rst), .i_wbs_we(we), .i_wbs_cyc(cyc), .i_wbs_sel(sel),
        .i_wbs_dat(dat), .i_wbs_stb(stb), .o_wbs_ack(ack32), .o_wbs_dat(rd32_o),
        .i_wbs_adr(adr), .o_wbs_int(irq32), .o_gpio_out(out32), .o_gpio_oe(oe32),
        .i_gpio_in(gpio_in));

    wb_gpio_ex #(.GPIO_WIDTH(8), .DEBOUNCE_DIV(4)) dut8 (
        .clk(clk), .rst(rst), .i_wbs_we(we), .i_wbs_cyc(cyc), .i_wbs_sel(sel),
        .i_wbs_dat(dat), .i_wbs_stb(stb), .o_wbs_ack(ack8), .o_wbs_dat(rd8_o),
        .i_wbs_adr(adr), .o_wbs_int(irq8), .o_gpio_out(out8), .o_gpio_oe(oe8),
        .i_gpio_in(gpio_in[7:0]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    logic [31:0] m_out, m_oe, m_pend, m_ien, m_edge, m_both, m_pad;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [3:0] s);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{s[i]}};
        return m;
    endfunction

    task automatic m_reset();
        m_out = 0; m_oe = 0; m_pend = 0; m_ien = 0; m_edge = 0; m_both = 0;
    endtask

    task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] bm, wv;
        bm = lanes(s);
        wv = d & bm;
        case (a)
            0: m_out  = (m_out  & ~bm) | wv;
            1: m_oe   = (m_oe   & ~bm) | wv;
            2: m_pend = m_pend & ~wv;
            3: m_ien  = (m_ien  & ~bm) | wv;
            4: m_edge = (m_edge & ~bm) | wv;
            5: m_both = (m_both & ~bm) | wv;
            6: m_out  = m_out | wv;
            7: m_out  = m_out & ~wv;
            default: ;
        endcase
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        case (a)
            0: return (m_pad & ~m_oe) | (m_out & m_oe);
            1: return m_oe;
            2: return m_pend;
            3: return m_ien;
            4: return m_edge;
            5: return m_both;
            default: return 32'h0;
        endcase
    endfunction

    // Called at #1 after a rising edge; returns at #1 after the edge following the ack.
    task automatic wb(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] r32, output logic [31:0] r8);
        int n = 0;
        logic got = 0;
        we = w; adr = a; dat = d; sel = s; cyc = 1; stb = 1;
        while (!got && n < 20) begin
            @(posedge clk); #1; n++;
            if (ack32) got = 1;
        end
        chk("wb_ack", {31'b0, got}, 1);
        chk("wb_ack8", {31'b0, ack8}, {31'b0, got});
        r32 = rd32_o; r8 = rd8_o;
        cyc = 0; stb = 0; we = 0;
        @(posedge clk); #1;
        chk("ack_one_cycle", {31'b0, ack32}, 0);
        if (w) m_write(a, d, s);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r32, r8;
        wb(1, a, d, 4'hF, r32, r8);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a);
        logic [31:0] r32, r8, e;
        e = m_read(a);
        wb(0, a, 32'h0, 4'hF, r32, r8);
        chk({tag, "_32"}, r32, e);
        chk({tag, "_8"}, r8, e & 32'hFF);
    endtask

    task automatic state_chk(input string tag);
        chk({tag, "_out"}, out32, m_out);
        chk({tag, "_oe"}, oe32, m_oe);
        chk({tag, "_int"}, {31'b0, irq32}, {31'b0, |(m_pend & m_ien)});
        chk({tag, "_out8"}, {24'b0, out8}, m_out & 32'hFF);
        chk({tag, "_oe8"}, {24'b0, oe8}, m_oe & 32'hFF);
        chk({tag, "_int8"}, {31'b0, irq8}, {31'b0, |(m_pend & m_ien & 32'hFF)});
    endtask

    task automatic set_pad(input logic [31:0] v);
        logic [31:0] ev;
        ev = (m_pad ^ v) & ~m_oe & (m_both | ~(m_edge ^ v));
        m_pend |= ev;
        m_pad = v;
        gpio_in = v;
        repeat (HOLD) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        gpio_in = 0; m_pad = 0;
        rst = 0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1;
        m_reset();
        repeat (HOLD) begin @(posedge clk); #1; end
    endtask

    initial begin
        logic [31:0] r32, r8, a, d;
        int n;
        rst = 0; we = 0; cyc = 0; stb = 0; sel = 0; dat = 0; adr = 0; gpio_in = 0;
        m_pad = 0; m_reset();
        repeat (3) begin @(posedge clk); #1; end
        chk("rst_ack", {31'b0, ack32}, 0);
        chk("rst_dat", rd32_o, 0);
        state_chk("rst");
        rst = 1;
        repeat (HOLD) begin @(posedge clk); #1; end

        // OE 0xFF then GPIO 0xA5 on the 8-bit instance
        wr(1, 32'hFF); wr(0, 32'hA5);
        chk("oe8_ff", {24'b0, oe8}, 32'hFF);
        chk("out8_a5", {24'b0, out8}, 32'hA5);
        wb(0, 0, 0, 4'hF, r32, r8);
        chk("rd8_a5", r8, 32'h0000_00A5);

        // byte-lane write
        wr(0, 32'hFFFF_FFFF);
        wb(1, 0, 32'h1234_5678, 4'b0001, r32, r8);
        chk("sel_lane", out32, 32'hFFFF_FF78);
        state_chk("sel");

        // rising-edge interrupt on bit0
        wr(1, 0); wr(2, 32'hFFFF_FFFF); wr(4, 1); wr(5, 0); wr(3, 1);
        set_pad(m_pad & ~32'h1);
        wr(2, 32'hFFFF_FFFF);
        gpio_in = m_pad | 32'h1;
        n = 0;
        while (!irq32 && n < 50) begin @(posedge clk); #1; n++; end
        chk("irq_latency", {31'b0, (n <= LAT)}, 1);
        m_pend |= 1; m_pad |= 1;
        repeat (HOLD) begin @(posedge clk); #1; end
        state_chk("rise");
        rd_chk("pend_rise", 2);
        wr(3, 0);
        rd_chk("mask_keeps", 2);
        wr(2, 1); wr(3, 1);
        set_pad(m_pad & ~32'h1);
        rd_chk("fall_none", 2);
        chk("fall_irq", {31'b0, irq32}, 0);

`ifndef GPIO_DEBOUNCE_EN
        // both-edge bit1, W1C coinciding with a third edge
        wr(5, 32'h2); wr(2, 32'hFFFF_FFFF); wr(3, 32'h2);
        set_pad(m_pad ^ 32'h2);
        set_pad(m_pad ^ 32'h2);
        rd_chk("both_two", 2);
        gpio_in = m_pad ^ 32'h2;
        @(posedge clk); #1;
        @(posedge clk); #1;
        wb(1, 2, 32'h2, 4'hF, r32, r8);
        m_pad ^= 32'h2; m_pend |= 32'h2;
        repeat (HOLD) begin @(posedge clk); #1; end
        wb(0, 2, 0, 4'hF, r32, r8);
        chk("w1c_race", r32 & 32'h2, 32'h2);
`else
        // glitch of two debounce ticks is filtered, a stable change is not
        wr(5, 32'hFFFF_FFFF); wr(2, 32'hFFFF_FFFF);
        gpio_in = m_pad ^ 32'h4;
        repeat (8) begin @(posedge clk); #1; end
        gpio_in = m_pad;
        repeat (HOLD) begin @(posedge clk); #1; end
        rd_chk("glitch", 2);
        set_pad(m_pad ^ 32'h4);
        rd_chk("stable", 2);
        chk("stable_bit", m_pend & 32'h4, 32'h4);
`endif

        // unmapped read
        wb(0, 9, 0, 4'hF, r32, r8);
        chk("unmapped", r32, 0);

        // randomized traffic against the model
        for (int i = 0; i < 120; i++) begin
            case ($urandom_range(2))
                0: set_pad($urandom);
                1: begin
                    a = $urandom_range(9); d = $urandom;
                    wb(1, a, d, 4'($urandom_range(15)), r32, r8);
                    state_chk("rnd_wr");
                end
                default: rd_chk("rnd_rd", $urandom_range(9));
            endcase
        end
        for (int r = 0; r < 6; r++) rd_chk("final", r);
        state_chk("final");

        // reset in the middle of a bus cycle
        gpio_in = 0;
        repeat (HOLD) begin @(posedge clk); #1; end
        we = 1; adr = 0; dat = 32'hFFFF_FFFF; sel = 4'hF; cyc = 1; stb = 1; rst = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("rst_no_ack", {31'b0, ack32}, 0);
        end
        cyc = 0; stb = 0; we = 0; rst = 1;
        m_reset(); m_pad = 0;
        @(posedge clk); #1;
        chk("rst_mid_ack", {31'b0, ack32}, 0);
        chk("rst_mid_dat", rd32_o, 0);
        state_chk("rst_mid");
        for (int r = 0; r < 8; r++) rd_chk("rst_reg", r);

        do_reset();
        state_chk("rst_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
